// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a 1..63 byte payload from an upstream byte stream,
// then serialises header {len,addr}, payload and an XOR parity byte toward
// the router input, holding the current byte while the router asserts busy.
// Optional feature macro: PKT_TX_BAD_PARITY_EN adds input corrupt_parity,
// sampled with start, which inverts the transmitted parity byte.
module router_pkt_tx #(
  parameter int MAX_LEN = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] payload_len,
  input  logic [1:0] dest_addr,
  input  logic       pl_valid,
  input  logic [7:0] pl_data,
`ifdef PKT_TX_BAD_PARITY_EN
  input  logic       corrupt_parity,
`endif
  input  logic       busy,
  output logic       pl_ready,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [5:0] r_len;
  logic [1:0] r_addr;
  logic [5:0] r_wr_idx;
  logic [5:0] r_rd_idx;
  logic [7:0] r_parity;
  logic [7:0] r_buf [0:MAX_LEN-1];

  logic [5:0] w_rd_next;
  logic [7:0] w_par_byte;

  assign w_rd_next = r_rd_idx + 6'd1;

`ifdef PKT_TX_BAD_PARITY_EN
  logic r_corrupt;
  assign w_par_byte = r_corrupt ? ~r_parity : r_parity;
`else
  assign w_par_byte = r_parity;
`endif

  // Payload buffer write; contents need no reset since every byte is rewritten in LOAD
  always_ff @(posedge clock) begin
    if (r_state == S_LOAD && pl_valid) begin
      r_buf[r_wr_idx] <= pl_data;
    end
  end

  // Control FSM; every output is registered and loaded with the value of the state being entered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_len     <= 6'd0;
      r_addr    <= 2'd0;
      r_wr_idx  <= 6'd0;
      r_rd_idx  <= 6'd0;
      r_parity  <= 8'h00;
`ifdef PKT_TX_BAD_PARITY_EN
      r_corrupt <= 1'b0;
`endif
      pl_ready  <= 1'b0;
      pkt_valid <= 1'b0;
      data_out  <= 8'h00;
      tx_active <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (payload_len != 6'd0 && dest_addr != 2'd3) begin
              r_state   <= S_LOAD;
              r_len     <= payload_len;
              r_addr    <= dest_addr;
              r_wr_idx  <= 6'd0;
              r_parity  <= {payload_len, dest_addr};
`ifdef PKT_TX_BAD_PARITY_EN
              r_corrupt <= corrupt_parity;
`endif
              pl_ready  <= 1'b1;
              tx_active <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (pl_valid) begin
            r_parity <= r_parity ^ pl_data;
            r_wr_idx <= r_wr_idx + 6'd1;
            // Last byte accepted: header becomes the first byte offered to the router
            if (r_wr_idx == r_len - 6'd1) begin
              r_state   <= S_HEADER;
              pl_ready  <= 1'b0;
              pkt_valid <= 1'b1;
              data_out  <= {r_len, r_addr};
            end
          end
        end
        S_HEADER: begin
          if (!busy) begin
            r_state  <= S_PAYLOAD;
            r_rd_idx <= 6'd0;
            data_out <= r_buf[0];
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            if (r_rd_idx == r_len - 6'd1) begin
              r_state   <= S_PARITY;
              pkt_valid <= 1'b0;
              data_out  <= w_par_byte;
            end else begin
              r_rd_idx <= w_rd_next;
              data_out <= r_buf[w_rd_next];
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            r_state  <= S_DONE;
            data_out <= 8'h00;
            done     <= 1'b1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          tx_active <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          pl_ready  <= 1'b0;
          pkt_valid <= 1'b0;
          data_out  <= 8'h00;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
